// File: rtl/agu_arbiter_pkg.sv
// Shared constants for the AGU arbiter: op codes, requester IDs and FSM states.
// A helper classifies which op codes the external AGU is allowed to execute.
package agu_arbiter_pkg;

  localparam logic [3:0] OP_LS_OFF16  = 4'd1;
  localparam logic [3:0] OP_BR_OFF18  = 4'd2;
  localparam logic [3:0] OP_JMP_OFF28 = 4'd3;

  localparam logic REQ_LS = 1'b0;
  localparam logic REQ_BR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_LS_OFF16) || (op == OP_BR_OFF18) || (op == OP_JMP_OFF28);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant: combinational grant, pointer advances only when the grant is consumed.
// With no requester valid the grant still points at the favoured side.
module rr_arbiter2
  import agu_arbiter_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_req_ls,
  input  logic i_req_br,
  input  logic i_update,
  output logic o_gnt_id
);

  // Last granted requester; resetting it to ls makes br win the first tie.
  logic r_last;
  logic w_gnt;

  always_comb begin
    w_gnt = ~r_last;
    if (i_req_ls && i_req_br) begin
      w_gnt = ~r_last;
    end else if (i_req_ls) begin
      w_gnt = REQ_LS;
    end else if (i_req_br) begin
      w_gnt = REQ_BR;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last <= REQ_LS;
    end else if (i_update) begin
      r_last <= w_gnt;
    end
  end

  assign o_gnt_id = w_gnt;

endmodule

// File: rtl/agu_arbiter.sv
// Arbitrates ls/br requesters onto one external AGU, one operation in flight (IDLE -> CALC -> RESP).
// Accept at cycle N gives o_res_valid at N+2; the result is held until i_res_ready, i_flush aborts.
module agu_arbiter
  import agu_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 26
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ls_valid,
  input  logic [3:0]        i_ls_op,
  input  logic [ADDR_W-1:0] i_ls_base,
  input  logic [OFF_W-1:0]  i_ls_offset,
  output logic              o_ls_ready,
  input  logic              i_br_valid,
  input  logic [3:0]        i_br_op,
  input  logic [ADDR_W-1:0] i_br_pc,
  input  logic [OFF_W-1:0]  i_br_offset,
  output logic              o_br_ready,
  output logic [3:0]        o_agu_op_code,
  output logic [ADDR_W-1:0] o_agu_addr,
  output logic [OFF_W-1:0]  o_agu_offset,
  input  logic [ADDR_W-1:0] i_agu_eff_addr,
  input  logic [1:0]        i_agu_addr_exception,
  output logic              o_res_valid,
  output logic [ADDR_W-1:0] o_res_addr,
  output logic [1:0]        o_res_exc,
  output logic              o_res_illegal,
  output logic              o_res_id,
  input  logic              i_res_ready,
  input  logic              i_flush,
  output logic              o_busy
);

  state_t r_state;
  state_t w_next;

  logic              r_op_vld;
  logic [3:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [OFF_W-1:0]  r_off;
  logic              r_id;

  logic [ADDR_W-1:0] r_res_addr;
  logic [1:0]        r_res_exc;
  logic              r_res_illegal;
  logic              r_res_id;

  logic w_gnt;
  logic w_hs;
  logic w_legal;

  rr_arbiter2 u_rr (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_req_ls (i_ls_valid),
    .i_req_br (i_br_valid),
    .i_update (w_hs),
    .o_gnt_id (w_gnt)
  );

  assign w_legal = is_legal_op(r_op);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_hs          = 1'b0;
    o_ls_ready    = 1'b0;
    o_br_ready    = 1'b0;
    o_busy        = 1'b1;
    o_res_valid   = 1'b0;
    o_agu_op_code = '0;
    o_agu_addr    = '0;
    o_agu_offset  = '0;
    case (r_state)
      ST_IDLE: begin
        o_busy     = 1'b0;
        o_ls_ready = (w_gnt == REQ_LS);
        o_br_ready = (w_gnt == REQ_BR);
        w_hs       = (w_gnt == REQ_LS) ? i_ls_valid : i_br_valid;
        if (w_hs) begin
          w_next = ST_CALC;
        end
      end
      ST_CALC: begin
        o_agu_op_code = r_op;
        o_agu_addr    = r_addr;
        o_agu_offset  = r_off;
        w_next        = i_flush ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        o_res_valid = 1'b1;
        // Flush wins over a simultaneous consume: the response is dropped.
        if (i_flush || i_res_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op_vld <= 1'b0;
      r_op     <= '0;
      r_addr   <= '0;
      r_off    <= '0;
      r_id     <= REQ_LS;
    end else if (w_hs) begin
      r_op_vld <= 1'b1;
      r_id     <= w_gnt;
      if (w_gnt == REQ_LS) begin
        r_op   <= i_ls_op;
        r_addr <= i_ls_base;
        r_off  <= i_ls_offset;
      end else begin
        r_op   <= i_br_op;
        r_addr <= i_br_pc;
        r_off  <= i_br_offset;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_res_addr    <= '0;
      r_res_exc     <= '0;
      r_res_illegal <= 1'b0;
      r_res_id      <= REQ_LS;
    end else if ((r_state == ST_CALC) && !i_flush && r_op_vld) begin
      // Illegal ops still spend the CALC cycle but never expose AGU output.
      r_res_addr    <= w_legal ? i_agu_eff_addr : '0;
      r_res_exc     <= w_legal ? i_agu_addr_exception : 2'b00;
      r_res_illegal <= ~w_legal;
      r_res_id      <= r_id;
    end
  end

  assign o_res_addr    = r_res_addr;
  assign o_res_exc     = r_res_exc;
  assign o_res_illegal = r_res_illegal;
  assign o_res_id      = r_res_id;

endmodule
